uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and bit-time helpers for the UART receiver.
package uart_pkg;

    // Clock cycles per bit for each unit of prescale.
    localparam int unsigned OVERSAMPLE = 8;

    // Width of the bit-time counters. It is wide enough for 16'hFFFF * 8.
    localparam int unsigned CNT_WIDTH = 19;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Reload value for a full bit time. A prescale of zero counts as one.
    function automatic logic [CNT_WIDTH-1:0] full_bit_count(input logic [15:0] ps);
        logic [CNT_WIDTH-1:0] eff;
        eff = CNT_WIDTH'((ps == 16'd0) ? 16'd1 : ps);
        return eff * CNT_WIDTH'(OVERSAMPLE) - CNT_WIDTH'(1);
    endfunction

    // Reload value for half a bit time. It is used to reach the middle of the start bit.
    function automatic logic [CNT_WIDTH-1:0] half_bit_count(input logic [15:0] ps);
        logic [CNT_WIDTH-1:0] eff;
        eff = CNT_WIDTH'((ps == 16'd0) ? 16'd1 : ps);
        return eff * CNT_WIDTH'(OVERSAMPLE / 2) - CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is set by a parameter.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Move the input into the clk domain through two stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with an AXI-stream style output.
// The optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] output_axi_tdata,
    output logic                  output_axi_tvalid,
    input  logic                  output_axi_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    input  logic [15:0]           prescale
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic                  rxd_s;
    rx_state_t             state, state_next;
    logic [CNT_WIDTH-1:0]  cnt, cnt_next;
    logic [15:0]           ps_lat, ps_lat_next;
    logic [IDX_W-1:0]      bit_idx, bit_idx_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic                  deliver;
    logic                  frame_err_evt;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit, par_bit_next;
    logic                  par_err_evt;
    logic                  parity_error_q;
`endif

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign busy = (state != IDLE);

    // Register the frame state: FSM state, bit timer, latched prescale, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ps_lat  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ps_lat  <= ps_lat_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_next;
`endif
        end
    end

    // Compute next-state and per-frame events. Every bit is sampled when the bit timer expires.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        ps_lat_next   = ps_lat;
        bit_idx_next  = bit_idx;
        shreg_next    = shreg;
        deliver       = 1'b0;
        frame_err_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next  = par_bit;
`endif
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    ps_lat_next = prescale;
                    cnt_next    = half_bit_count(prescale);
                    state_next  = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rxd_s) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next     = full_bit_count(ps_lat);
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_next = {rxd_s, shreg[DATA_WIDTH-1:1]};
                    cnt_next   = full_bit_count(ps_lat);
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt == '0) begin
                    par_bit_next = rxd_s;
                    cnt_next     = full_bit_count(ps_lat);
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
`else
                state_next = IDLE;
`endif
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rxd_s) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_evt = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the data bits and the parity bit together must hold an even number of ones.
    always_comb begin
        par_err_evt = deliver && ((^shreg) ^ par_bit);
    end
`endif

    // Output handshake. A delivery while tvalid is high and tready is low overwrites the held character and flags an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_axi_tdata  <= '0;
            output_axi_tvalid <= 1'b0;
            overrun_error     <= 1'b0;
            frame_error       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q    <= 1'b0;
`endif
        end else begin
            frame_error <= frame_err_evt;
            if (deliver) begin
                output_axi_tdata  <= shreg;
                output_axi_tvalid <= 1'b1;
                overrun_error     <= output_axi_tvalid && !output_axi_tready;
`ifdef UART_RX_PARITY_EN
                parity_error_q    <= par_err_evt;
`endif
            end else begin
                overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_error_q <= 1'b0;
`endif
                if (output_axi_tready) begin
                    output_axi_tvalid <= 1'b0;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard testbench for uart_rx. Directed frames push their expected characters into a queue, and a monitor pops and checks each accepted character.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        busy;
    logic        ov_err;
    logic        fr_err;
    logic        pa_err;
    logic [15:0] prescale = 16'd1;

    int errors = 0;
    int checks = 0;

    int vcyc = 0;
    int fe_cyc = 0;
    int ov_cyc = 0;
    int pe_cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];

    uart_rx #(
        .DATA_WIDTH(8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rxd               (rxd),
        .output_axi_tdata  (tdata),
        .output_axi_tvalid (tvalid),
        .output_axi_tready (tready),
        .busy              (busy),
        .overrun_error     (ov_err),
        .frame_error       (fr_err),
        .parity_error      (pa_err),
        .prescale          (prescale)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every accepted character, and count the output pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid) vcyc++;
            if (fr_err) fe_cyc++;
            if (ov_err) ov_cyc++;
            if (pa_err) pe_cyc++;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got tdata=%0h expected none", tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tdata", 32'(tdata), 32'(e.data));
                    check("parity_error", 32'(pa_err), 32'(e.perr));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one serial frame: the bit timing comes from ps. The prescale port is set to ps_port at the start and to ps_after once the start bit ends.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par,
                              input int ps, input logic [15:0] ps_port, input logic [15:0] ps_after);
        prescale = ps_port;
        rxd = 1'b0;
        tick(8 * ps);
        prescale = ps_after;
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            tick(8 * ps);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        tick(8 * ps);
`else
        if (par === 1'bx) rxd = 1'b1;
`endif
        rxd = stop_bit;
        tick(8 * ps);
        rxd = 1'b1;
    endtask

    initial begin
        int v0, f0, o0, p0;

        // Reset state
        tick(4);
        check("rst_tdata", 32'(tdata), 32'h0);
        check("rst_tvalid", 32'(tvalid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_errors", {29'd0, ov_err, fr_err, pa_err}, 32'h0);
        rst = 1'b0;
        tick(5);

        // prescale=1, frame 0x55, tready=1
        v0 = vcyc; f0 = fe_cyc; o0 = ov_cyc;
        exp_q.push_back('{8'h55, 1'b0});
        send_frame(8'h55, 1'b1, ^8'h55, 1, 16'd1, 16'd1);
        tick(12);
        check("p1_vcycles", 32'(vcyc - v0), 32'd1);
        check("p1_busy", 32'(busy), 32'h0);
        check("p1_errs", 32'((fe_cyc - f0) + (ov_cyc - o0)), 32'd0);
        check("p1_queue", 32'(exp_q.size()), 32'd0);

        // prescale=2, frame 0xA3 with stop bit 0
        v0 = vcyc; f0 = fe_cyc;
        send_frame(8'hA3, 1'b0, ^8'hA3, 2, 16'd2, 16'd2);
        tick(40);
        check("fe_pulse", 32'(fe_cyc - f0), 32'd1);
        check("fe_no_tvalid", 32'(vcyc - v0), 32'd0);
        check("fe_busy", 32'(busy), 32'h0);

        // prescale=1, 0x11 then 0x22 back-to-back with tready=0
        o0 = ov_cyc; f0 = fe_cyc;
        tready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11, 1, 16'd1, 16'd1);
        send_frame(8'h22, 1'b1, ^8'h22, 1, 16'd1, 16'd1);
        tick(10);
        check("ov_pulse", 32'(ov_cyc - o0), 32'd1);
        check("ov_tvalid", 32'(tvalid), 32'h1);
        check("ov_tdata", 32'(tdata), 32'h22);
        check("ov_no_fe", 32'(fe_cyc - f0), 32'd0);
        exp_q.push_back('{8'h22, 1'b0});
        tready = 1'b1;
        tick(3);
        check("ov_drained", 32'(exp_q.size()), 32'd0);
        check("ov_tvalid_clear", 32'(tvalid), 32'h0);

        // prescale=4, 3-clock low glitch is rejected at the half-bit point
        v0 = vcyc; f0 = fe_cyc; o0 = ov_cyc;
        prescale = 16'd4;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(3);
        check("gl_busy_rise", 32'(busy), 32'h1);
        tick(12);
        check("gl_busy_before_half", 32'(busy), 32'h1);
        tick(2);
        check("gl_busy_fall", 32'(busy), 32'h0);
        tick(20);
        check("gl_no_tvalid", 32'(vcyc - v0), 32'd0);
        check("gl_no_errs", 32'((fe_cyc - f0) + (ov_cyc - o0)), 32'd0);

        // prescale port 0 behaves as 1
        exp_q.push_back('{8'hC6, 1'b0});
        send_frame(8'hC6, 1'b1, ^8'hC6, 1, 16'd0, 16'd0);
        tick(12);
        check("ps0_queue", 32'(exp_q.size()), 32'd0);

        // prescale change mid-frame is ignored until the next start bit
        exp_q.push_back('{8'h9A, 1'b0});
        send_frame(8'h9A, 1'b1, ^8'h9A, 2, 16'd2, 16'd7);
        tick(20);
        check("psmid_queue", 32'(exp_q.size()), 32'd0);

        // reset during 4th data bit of 0xFF, then 0x3C
        f0 = fe_cyc; o0 = ov_cyc;
        prescale = 16'd1;
        rxd = 1'b0;
        tick(8);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b1;
            tick(8);
        end
        tick(4);
        rst = 1'b1;
        tick(2);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_tdata", 32'(tdata), 32'h0);
        check("mid_rst_tvalid", 32'(tvalid), 32'h0);
        rst = 1'b0;
        tick(20);
        exp_q.push_back('{8'h3C, 1'b0});
        send_frame(8'h3C, 1'b1, ^8'h3C, 1, 16'd1, 16'd1);
        tick(12);
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        check("mid_rst_no_errs", 32'((fe_cyc - f0) + (ov_cyc - o0)), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong and parity bit 1 is right
        p0 = pe_cyc;
        exp_q.push_back('{8'h07, 1'b1});
        send_frame(8'h07, 1'b1, 1'b0, 1, 16'd1, 16'd1);
        tick(12);
        exp_q.push_back('{8'h07, 1'b0});
        send_frame(8'h07, 1'b1, 1'b1, 1, 16'd1, 16'd1);
        tick(12);
        check("par_pulses", 32'(pe_cyc - p0), 32'd1);
        check("par_queue", 32'(exp_q.size()), 32'd0);
`else
        p0 = 0;
        check("par_never", 32'(pe_cyc + p0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
